vpu_seq: RTL and testbench
==========================

Name: vpu_seq

Overview:
- Sequencer for the 8-lane x 16-bit vector unit. Accepts one vector command of up to 64 elements and splits it into 8-element beats.
- Each beat: issues a register-file read, drives the unit's function selects and per-lane mask, then issues a masked writeback of the result.
- Compare commands collect the unit's 8-bit per-beat compare results into one 64-bit result word.
- Sits between the vector issue stage and the vector unit/register file, one command in flight.

Parameters:
- MAXVL, 64, maximum elements per command; must be a multiple of 8. Beats = MAXVL/8.
- BW, 3, beat index width, log2(MAXVL/8).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  5  opcode: 0 add, 1 sub, 2 mul, 3 itf, 4 fti, 5 ftl, 6 max, 7 min, 8 and, 9 or, 10 xor, 11 sra, 12 srl, 13 sll, 14 cge, 15 clt, 16 ceq, 17 cnq; 18-31 illegal
- cmd_ifsel  in  1  1 = float path, 0 = integer path
- cmd_vl  in  7  element count, 0..127; values above MAXVL are clamped to MAXVL
- cmd_masken  in  1  apply cmd_mask
- cmd_mask  in  MAXVL  per-element mask
- rf_re  out  1  operand read strobe
- rf_rbeat  out  BW  beat being read; operands are returned one cycle later
- vpu_ifsel  out  1  registered copy of cmd_ifsel
- vpu_sel  out  18  one-hot function select; bit n corresponds to opcode n
- vpu_mask  out  8  lane enables for the beat currently at writeback
- vpu_rd  in  8  low 8 bits of the vector unit's scalar result (compare bits)
- wb_we  out  1  result write strobe
- wb_beat  out  BW  beat being written
- wb_lane_en  out  8  per-lane write enables; equal to vpu_mask
- cmp_result  out  MAXVL  collected compare bits
- done  out  1  one-cycle completion pulse
- err  out  1  valid together with done; indicates an illegal opcode
- busy  out  1  sequencer is not in IDLE

Behaviour:
- Reset values: all outputs 0 except cmd_ready = 1. cmp_result = 0. State = IDLE.
- Reset asserted mid-command aborts immediately: no further rf_re or wb_we, and no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch op, ifsel, clamped vl, masken and mask.
  - Compute N = ceil(vl/8).
  - If the command is a compare, clear cmp_result at acceptance.
  - Go to DONE if vl == 0 or the opcode is illegal; otherwise go to RUN.
- RUN:
  - Read side: cycle k (k = 0..N-1 after entry) drives rf_re = 1 and rf_rbeat = k.
  - Writeback side lags by one cycle: cycle k+1 drives wb_we = 1, wb_beat = k, vpu_mask/wb_lane_en = lanemask(k).
  - One beat per cycle, no bubbles.
  - Go to DONE the cycle after the last writeback (cycle N after entry).
- vpu_sel and vpu_ifsel are held constant from the first RUN cycle through the last writeback. They are 0 in IDLE and DONE, and 0 for illegal opcodes.
- lanemask(b), bit i = (8b+i < vl) && (!masken || mask[8b+i]).
- A beat whose lanemask is all zero still occupies its cycle: wb_we = 1 with wb_lane_en = 0.
- Compare ops (14-17), on each writeback cycle of beat b: cmp_result[8b+i] <= vpu_rd[i] & lanemask(b)[i].
- Non-compare ops leave cmp_result unchanged.
- DONE:
  - done = 1 for exactly one cycle.
  - err = 1 for an illegal opcode; err is 0 for vl == 0 with a legal opcode.
  - cmp_result is stable and holds until the next compare command is accepted.
  - Next state is IDLE.
- cmd_ready = 0 in RUN and DONE. A command offered during those states is not consumed, and the issuer holds it.
- Latency: command accept at cycle 0. First read at cycle 1, first writeback at cycle 2, done at cycle N+2. The next accept is possible at cycle N+3.
- cmd_vl > MAXVL: treated exactly as vl = MAXVL.
- busy = (state != IDLE).

Test Plan:
- add, ifsel = 0, vl = 64, masken = 0 -> rf_rbeat 0..7 on cycles 1-8; wb_beat 0..7 on cycles 2-9, all with wb_lane_en = 0xFF; vpu_sel = 0x00001; done at cycle 10.
- mul, vl = 13, masken = 1, mask = 0x1FFE -> N = 2; beat0 lane_en = 0xFE; beat1 lane_en = 0x1F; done at cycle 4.
- ceq, vl = 20, masken = 0, vpu_rd driven 0xFF every beat -> cmp_result = 0x00000000000FFFFF at done; beat2 lane_en = 0x0F.
- vl = 0 with a legal opcode, and separately cmd_op = 25 -> no rf_re or wb_we; done at cycle 1 in both cases; err = 0 for the first, err = 1 for the second.
- vl = 100 -> behaves as vl = 64 (8 beats, all lanes enabled).
- Back-to-back: a second command held valid during RUN is not accepted until IDLE, then accepted at cycle N+3. Separately, asserting rst at cycle 4 of a 64-element command -> outputs return to reset values at once; no done pulse; cmd_ready = 1 after rst drops.

Source files
------------

// File: rtl/vpu_seq.sv
// Vector unit sequencer: splits one vector command into 8-lane beats,
// drives read, function select, lane mask and masked writeback.
module vpu_seq #(
   parameter int MAXVL = 64,
   parameter int BW    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [4:0]       cmd_op,
   input  logic             cmd_ifsel,
   input  logic [6:0]       cmd_vl,
   input  logic             cmd_masken,
   input  logic [MAXVL-1:0] cmd_mask,
   output logic             rf_re,
   output logic [BW-1:0]    rf_rbeat,
   output logic             vpu_ifsel,
   output logic [17:0]      vpu_sel,
   output logic [7:0]       vpu_mask,
   input  logic [7:0]       vpu_rd,
   output logic             wb_we,
   output logic [BW-1:0]    wb_beat,
   output logic [7:0]       wb_lane_en,
   output logic [MAXVL-1:0] cmp_result,
   output logic             done,
   output logic             err,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [6:0]       vl_q;
   logic             masken_q;
   logic [MAXVL-1:0] mask_q;
   logic [BW-1:0]    last_q;
   logic             cmp_q;

   logic [6:0]       vl_c;
   logic [7:0]       span_c;
   logic [7:0]       nb_c;
   logic [BW-1:0]    last_c;
   logic             legal_c;
   logic             iscmp_c;
   logic [17:0]      sel_c;
   logic [7:0]       lm;
   logic [BW+2:0]    ix;

   // Decode the offered command: clamp length, beat count, select.
   always_comb begin
      vl_c    = (cmd_vl > 7'(MAXVL)) ? 7'(MAXVL) : cmd_vl;
      span_c  = {1'b0, vl_c} + 8'd7;
      nb_c    = span_c >> 3;
      last_c  = BW'(nb_c - 8'd1);
      legal_c = (cmd_op < 5'd18);
      iscmp_c = (cmd_op >= 5'd14) && (cmd_op <= 5'd17);
      sel_c   = legal_c ? (18'd1 << cmd_op) : 18'd0;
   end

   // Lane mask for the beat currently being read.
   always_comb begin
      lm = '0;
      ix = '0;
      for (int i = 0; i < 8; i++) begin
         ix    = {rf_rbeat, 3'(i)};
         lm[i] = (8'(ix) < {1'b0, vl_q}) &&
                 (!masken_q || mask_q[ix]);
      end
   end

   assign wb_lane_en = vpu_mask;

   // Sequencer FSM with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cmd_ready  <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         rf_re      <= 1'b0;
         rf_rbeat   <= '0;
         wb_we      <= 1'b0;
         wb_beat    <= '0;
         vpu_mask   <= '0;
         vpu_sel    <= '0;
         vpu_ifsel  <= 1'b0;
         cmp_result <= '0;
         vl_q       <= '0;
         masken_q   <= 1'b0;
         mask_q     <= '0;
         last_q     <= '0;
         cmp_q      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               err  <= 1'b0;
               if (cmd_valid) begin
                  vl_q      <= vl_c;
                  masken_q  <= cmd_masken;
                  mask_q    <= cmd_mask;
                  last_q    <= last_c;
                  cmp_q     <= iscmp_c;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (iscmp_c)
                     cmp_result <= '0;
                  if (vl_c == 7'd0 || !legal_c) begin
                     state <= DONE;
                     done  <= 1'b1;
                     err   <= !legal_c;
                  end else begin
                     state     <= RUN;
                     rf_re     <= 1'b1;
                     rf_rbeat  <= '0;
                     vpu_sel   <= sel_c;
                     vpu_ifsel <= cmd_ifsel;
                  end
               end
            end
            RUN: begin
               wb_we    <= rf_re;
               wb_beat  <= rf_rbeat;
               vpu_mask <= rf_re ? lm : 8'd0;
               if (rf_re) begin
                  if (rf_rbeat == last_q) begin
                     rf_re    <= 1'b0;
                     rf_rbeat <= '0;
                  end else begin
                     rf_rbeat <= rf_rbeat + 1'b1;
                  end
               end
               if (wb_we && cmp_q)
                  cmp_result[{wb_beat, 3'b000} +: 8] <= vpu_rd & vpu_mask;
               if (wb_we && !rf_re) begin
                  state     <= DONE;
                  done      <= 1'b1;
                  vpu_sel   <= '0;
                  vpu_ifsel <= 1'b0;
               end
            end
            DONE: begin
               state     <= IDLE;
               done      <= 1'b0;
               err       <= 1'b0;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vpu_seq.sv
// Scoreboard bench for vpu_seq: random and directed commands,
// expected beat/writeback/done events queued per absolute cycle.
module tb_vpu_seq;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [4:0]  cmd_op;
   logic        cmd_ifsel;
   logic [6:0]  cmd_vl;
   logic        cmd_masken;
   logic [63:0] cmd_mask;
   logic        rf_re;
   logic [2:0]  rf_rbeat;
   logic        vpu_ifsel;
   logic [17:0] vpu_sel;
   logic [7:0]  vpu_mask;
   logic [7:0]  vpu_rd;
   logic        wb_we;
   logic [2:0]  wb_beat;
   logic [7:0]  wb_lane_en;
   logic [63:0] cmp_result;
   logic        done;
   logic        err;
   logic        busy;

   vpu_seq #(.MAXVL(64), .BW(3)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_ifsel(cmd_ifsel), .cmd_vl(cmd_vl),
      .cmd_masken(cmd_masken), .cmd_mask(cmd_mask),
      .rf_re(rf_re), .rf_rbeat(rf_rbeat),
      .vpu_ifsel(vpu_ifsel), .vpu_sel(vpu_sel), .vpu_mask(vpu_mask),
      .vpu_rd(vpu_rd),
      .wb_we(wb_we), .wb_beat(wb_beat), .wb_lane_en(wb_lane_en),
      .cmp_result(cmp_result), .done(done), .err(err), .busy(busy)
   );

   typedef struct {
      int          cyc;
      int          beat;
      logic [7:0]  lane;
      logic [17:0] sel;
      logic        ifs;
      logic        err;
      logic [63:0] cmp;
   } ev_t;
   typedef ev_t evq_t[$];

   evq_t        rq, wq, dq;
   int          cyc = 0;
   int          total = 0;
   int          passed = 0;
   logic [7:0]  rdtab [4096];
   logic        rd_ff = 1'b0;
   logic [63:0] mcmp = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                    nm, act, exp, cyc);
   endtask

   function automatic logic [7:0] rdval(input int c);
      return rd_ff ? 8'hFF : rdtab[c % 4096];
   endfunction

   function automatic evq_t purge(input evq_t q, input int lim);
      evq_t t;
      t = {};
      foreach (q[i]) if (q[i].cyc < lim) t.push_back(q[i]);
      return t;
   endfunction

   // Reference model: events derived from element-level rules.
   task automatic model(input logic [4:0] op, input logic ifs,
                        input logic [6:0] vl, input logic me,
                        input logic [63:0] m, input int a);
      int         vle;
      int         n;
      logic       legal;
      logic       isc;
      logic [7:0] lane [8];
      logic [7:0] rv;
      ev_t        e;
      vle   = (vl > 64) ? 64 : int'(vl);
      legal = (op < 18);
      isc   = (op >= 14) && (op <= 17);
      for (int b = 0; b < 8; b++) lane[b] = '0;
      for (int k = 0; k < vle; k++)
         if (!me || m[k]) lane[k / 8][k % 8] = 1'b1;
      if (isc) mcmp = '0;
      e = '{cyc: 0, beat: 0, lane: 0, sel: 0, ifs: 0, err: 0, cmp: 0};
      if (!legal || vle == 0) begin
         e.cyc = a + 1;
         e.err = !legal;
         e.cmp = mcmp;
         dq.push_back(e);
         return;
      end
      n = (vle + 7) / 8;
      for (int b = 0; b < n; b++) begin
         e.cyc  = a + 1 + b;
         e.beat = b;
         rq.push_back(e);
         e.cyc  = a + 2 + b;
         e.lane = lane[b];
         e.sel  = 18'd1 << op;
         e.ifs  = ifs;
         wq.push_back(e);
         if (isc) begin
            rv = rdval(a + 2 + b);
            for (int i = 0; i < 8; i++)
               mcmp[8 * b + i] = rv[i] & lane[b][i];
         end
      end
      e.cyc = a + n + 2;
      e.err = 1'b0;
      e.cmp = mcmp;
      dq.push_back(e);
   endtask

   // Monitor: drives vpu_rd and pops/compares on every DUT event.
   initial begin
      ev_t e;
      vpu_rd = '0;
      forever begin
         @(negedge clk);
         vpu_rd = rdval(cyc);
         if (rf_re) begin
            if (rq.size() == 0) chk("rf_re_unexpected", 1, 0);
            else begin
               e = rq.pop_front();
               chk("rd_cycle", cyc, e.cyc);
               chk("rd_beat", rf_rbeat, e.beat);
            end
         end
         if (wb_we) begin
            if (wq.size() == 0) chk("wb_we_unexpected", 1, 0);
            else begin
               e = wq.pop_front();
               chk("wb_cycle", cyc, e.cyc);
               chk("wb_beat", wb_beat, e.beat);
               chk("wb_lane_en", wb_lane_en, e.lane);
               chk("vpu_mask", vpu_mask, e.lane);
               chk("vpu_sel", vpu_sel, e.sel);
               chk("vpu_ifsel", vpu_ifsel, e.ifs);
            end
         end
         if (done) begin
            if (dq.size() == 0) chk("done_unexpected", 1, 0);
            else begin
               e = dq.pop_front();
               chk("done_cycle", cyc, e.cyc);
               chk("err", err, e.err);
               chk("cmp_result", cmp_result, e.cmp);
            end
         end else if (err) chk("err_without_done", err, 0);
         if (rf_re || wb_we || done) chk("busy", busy, 1);
         if (!rf_re && !wb_we && (vpu_sel != 0 || vpu_ifsel))
            chk("sel_idle", {vpu_ifsel, vpu_sel}, 0);
      end
   end

   task automatic send(input logic [4:0] op, input logic ifs,
                       input logic [6:0] vl, input logic me,
                       input logic [63:0] m, output int a);
      int n;
      cmd_op     = op;
      cmd_ifsel  = ifs;
      cmd_vl     = vl;
      cmd_masken = me;
      cmd_mask   = m;
      cmd_valid  = 1'b1;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      a = cyc;
      if (!cmd_ready) chk("accept_timeout", 0, 1);
      else model(op, ifs, vl, me, m, a);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (dq.size() != 0 && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain", dq.size() + rq.size() + wq.size(), 0);
   endtask

   task automatic chk_reset();
      chk("rst_ready", cmd_ready, 1);
      chk("rst_outs", {rf_re, wb_we, done, err, busy, vpu_ifsel}, 0);
      chk("rst_sel", {vpu_sel, vpu_mask, wb_lane_en}, 0);
      chk("rst_beats", {rf_rbeat, wb_beat}, 0);
      chk("rst_cmp", cmp_result, 0);
   endtask

   initial begin
      int a, a2, g;
      logic [4:0] op;
      logic [6:0] vl;
      foreach (rdtab[i]) rdtab[i] = 8'($urandom);
      rst        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_op     = '0;
      cmd_ifsel  = 1'b0;
      cmd_vl     = '0;
      cmd_masken = 1'b0;
      cmd_mask   = '0;
      repeat (3) @(negedge clk);
      chk_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;

      send(5'd0, 1'b0, 7'd64, 1'b0, 64'd0, a);
      drain();
      send(5'd2, 1'b1, 7'd13, 1'b1, 64'h1FFE, a);
      drain();
      rd_ff = 1'b1;
      send(5'd16, 1'b0, 7'd20, 1'b0, 64'(~0), a);
      drain();
      @(negedge clk);
      chk("ceq_cmp_hold", cmp_result, 64'hFFFFF);
      @(posedge clk);
      #1;
      rd_ff = 1'b0;
      send(5'd0, 1'b0, 7'd0, 1'b0, 64'd0, a);
      drain();
      send(5'd25, 1'b0, 7'd40, 1'b0, 64'd0, a);
      drain();
      send(5'd10, 1'b0, 7'd100, 1'b0, 64'd0, a);
      drain();
      send(5'd1, 1'b0, 7'd20, 1'b0, 64'd0, a);
      send(5'd6, 1'b1, 7'd9, 1'b0, 64'd0, a2);
      chk("b2b_accept", a2, a + 3 + 3);
      drain();

      for (int t = 0; t < 40; t++) begin
         op = 5'($urandom_range(0, 31));
         if (t % 3 == 0) op = 5'($urandom_range(14, 17));
         vl = 7'($urandom_range(0, 127));
         if (t % 7 == 0) vl = 7'd0;
         send(op, 1'($urandom), vl, 1'($urandom),
              {$urandom, $urandom}, a);
         g = $urandom_range(0, 2);
         repeat (g) begin
            @(posedge clk);
            #1;
         end
      end
      drain();

      send(5'd0, 1'b0, 7'd64, 1'b0, 64'd0, a);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_cycle", cyc, a + 4);
      chk_reset();
      rq = purge(rq, a + 4);
      wq = purge(wq, a + 4);
      dq = purge(dq, a + 4);
      mcmp = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", cmd_ready, 1);
      @(posedge clk);
      #1;
      send(5'd17, 1'b0, 7'd64, 1'b1, {$urandom, $urandom}, a);
      drain();
      repeat (3) @(posedge clk);
      chk("final_empty", rq.size() + wq.size() + dq.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
